hls_deadlock_watchdog: RTL

//  Parametrised deadlock monitor for one HLS dataflow instance with NUM_PROC processes.

---
 rtl/hls_deadlock_watchdog.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hls_deadlock_watchdog.sv
// Deadlock monitor for one HLS dataflow instance: flags a persistent
// all-stopped condition with at least one AXIS-blocked process.
module hls_deadlock_watchdog #(
   parameter int NUM_PROC  = 2,
   parameter int THRESHOLD = 16,
   parameter int CNT_W     = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   input  logic [NUM_PROC-1:0] axis_block_sigs,
   input  logic [NUM_PROC-1:0] inst_idle_sigs,
   input  logic [NUM_PROC-1:0] inst_block_sigs,
   output logic                block,
   output logic                block_sticky,
   output logic [NUM_PROC-1:0] block_proc_vec,
   output logic [CNT_W-1:0]    stall_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_BLK  = 2'd2;

   localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESHOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    persist_q, persist_d;
   logic                sticky_q, sticky_d;
   logic [NUM_PROC-1:0] snap_q, snap_d;
   logic [CNT_W-1:0]    stall_q, stall_d;

   logic [NUM_PROC-1:0] stop;
   logic                cand;
   logic                live;

   assign stop = inst_idle_sigs | inst_block_sigs | axis_block_sigs;
   assign cand = (|axis_block_sigs) & (&stop);
   assign live = enable & cand;

   always_comb begin
      state_d   = state_q;
      persist_d = persist_q;
      sticky_d  = sticky_q;
      snap_d    = snap_q;
      stall_d   = stall_q;

      case (state_q)
         S_IDLE: begin
            if (live) begin
               if (THRESHOLD == 1) begin
                  state_d = S_BLK;
               end else begin
                  state_d   = S_ARM;
                  persist_d = CNT_W'(1);
               end
            end
         end
         S_ARM: begin
            if (!live) begin
               state_d   = S_IDLE;
               persist_d = '0;
            end else if (persist_q == THR_M1) begin
               state_d = S_BLK;
            end else begin
               persist_d = persist_q + CNT_W'(1);
            end
         end
         S_BLK: begin
            if (!live) begin
               state_d   = S_IDLE;
               persist_d = '0;
            end
         end
         default: begin
            state_d   = S_IDLE;
            persist_d = '0;
         end
      endcase

      // Fresh entry restarts the snapshot; staying in BLOCKED accumulates.
      if (state_d == S_BLK && state_q != S_BLK) begin
         sticky_d = 1'b1;
         snap_d   = axis_block_sigs;
         stall_d  = CNT_W'(1);
      end else if (state_d == S_BLK && stall_q != CNT_MAX) begin
         stall_d = stall_q + CNT_W'(1);
      end

      // Clear wins over a same-cycle entry so detection starts over.
      if (clear) begin
         state_d   = S_IDLE;
         persist_d = '0;
         sticky_d  = 1'b0;
         snap_d    = '0;
         stall_d   = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         persist_q <= '0;
         sticky_q  <= 1'b0;
         snap_q    <= '0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         persist_q <= persist_d;
         sticky_q  <= sticky_d;
         snap_q    <= snap_d;
         stall_q   <= stall_d;
      end
   end

   assign block          = (state_q == S_BLK);
   assign block_sticky   = sticky_q;
   assign block_proc_vec = snap_q;
   assign stall_count    = stall_q;

endmodule
